// File: rtl/mul16_pp_sequencer.sv
// Sequential 2W x 2W unsigned multiplier. It drives an external W x W array
// multiplier with one operand-half pair per cycle and adds the four returned
// partial products into a 4W-bit accumulator through one shared 2W-bit
// ripple adder.

// Shared 2W-bit ripple-carry adder.
module mul16_pp_ripple_add #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    // Bit-serial carry propagation, evaluated LSB first.
    always_comb begin
        logic carry;
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < N; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end
endmodule

module mul16_pp_sequencer #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           start_i,
    input  logic [2*W-1:0] a_i,
    input  logic [2*W-1:0] b_i,
    output logic [W-1:0]   pp_a_o,
    output logic [W-1:0]   pp_b_o,
    input  logic [2*W-1:0] pp_in_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [4*W-1:0] product_o
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4
    } state_t;

    state_t         state_q;
    logic [2*W-1:0] a_q;
    logic [2*W-1:0] b_q;
    logic [4*W-1:0] acc_q;
    logic [4*W-1:0] product_q;
    logic [W-1:0]   pp_a_q;
    logic [W-1:0]   pp_b_q;
    logic           busy_q;
    logic           done_q;

    logic [2*W-1:0] add_a_d;
    logic [2*W-1:0] add_b_d;
    logic [2*W-1:0] add_sum;
    logic           add_cout;

    // Adder operand mux: middle 2W bits in PP1/PP2, upper 2W bits in PP3.
    always_comb begin
        add_a_d = '0;
        add_b_d = '0;
        case (state_q)
            S_PP1, S_PP2: begin
                add_a_d = acc_q[3*W-1:W];
                add_b_d = pp_in_i;
            end
            S_PP3: begin
                add_a_d = acc_q[4*W-1:2*W];
                add_b_d = pp_in_i;
            end
            default: ;
        endcase
    end

    mul16_pp_ripple_add #(.N(2*W)) u_add (
        .a_i    (add_a_d),
        .b_i    (add_b_d),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Sequencer FSM with registered operand halves, status and result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            pp_a_q    <= '0;
            pp_b_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        pp_a_q  <= a_i[W-1:0];
                        pp_b_q  <= b_i[W-1:0];
                        busy_q  <= 1'b1;
                        state_q <= S_PP0;
                    end
                end
                S_PP0: begin
                    acc_q   <= {{(2*W){1'b0}}, pp_in_i};
                    pp_a_q  <= a_q[W-1:0];
                    pp_b_q  <= b_q[2*W-1:W];
                    state_q <= S_PP1;
                end
                S_PP1: begin
                    acc_q[3*W-1:W]   <= add_sum;
                    acc_q[4*W-1:3*W] <= {{(W-1){1'b0}}, add_cout};
                    pp_a_q           <= a_q[2*W-1:W];
                    pp_b_q           <= b_q[W-1:0];
                    state_q          <= S_PP2;
                end
                S_PP2: begin
                    // Top byte holds at most 1 here, so adding one carry cannot wrap.
                    acc_q[3*W-1:W]   <= add_sum;
                    acc_q[4*W-1:3*W] <= acc_q[4*W-1:3*W] + {{(W-1){1'b0}}, add_cout};
                    pp_a_q           <= a_q[2*W-1:W];
                    pp_b_q           <= b_q[2*W-1:W];
                    state_q          <= S_PP3;
                end
                S_PP3: begin
                    // The final carry is always 0 since a*b fits in 4W bits.
                    acc_q[4*W-1:2*W] <= add_sum;
                    product_q        <= {add_sum, acc_q[2*W-1:0]};
                    pp_a_q           <= '0;
                    pp_b_q           <= '0;
                    busy_q           <= 1'b0;
                    done_q           <= 1'b1;
                    state_q          <= S_IDLE;
                end
                default: begin
                    pp_a_q  <= '0;
                    pp_b_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pp_a_o    = pp_a_q;
    assign pp_b_o    = pp_b_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;
endmodule

// File: tb/tb_mul16_pp_sequencer.sv
// Directed and random checks for mul16_pp_sequencer (W=8) with a behavioural
// array multiplier feeding pp_in.
module tb_mul16_pp_sequencer;
    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   a_r;
    logic [15:0]   b_r;
    logic [7:0]    pp_a;
    logic [7:0]    pp_b;
    logic [15:0]   pp_in;
    logic          busy;
    logic          done;
    logic [31:0]   product;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_prod = 32'd0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];
    logic [15:0] ha[15];
    logic [15:0] hb[15];

    mul16_pp_sequencer #(.W(W)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .a_i       (a_r),
        .b_i       (b_r),
        .pp_a_o    (pp_a),
        .pp_b_o    (pp_b),
        .pp_in_i   (pp_in),
        .busy_o    (busy),
        .done_o    (done),
        .product_o (product)
    );

    // External array multiplier: combinational, same cycle.
    assign pp_in = 16'(pp_a) * 16'(pp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation, checking every cycle from acceptance to done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        logic [7:0] ea;
        logic [7:0] eb;
        a_r   = a;
        b_r   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_r   = ~a;
        b_r   = ~b;
        for (int i = 0; i < 4; i++) begin
            ea = (i < 2) ? a[7:0] : a[15:8];
            eb = (i % 2 == 0) ? b[7:0] : b[15:8];
            chk("busy_in_pp", 32'(busy), 32'd1);
            chk("done_in_pp", 32'(done), 32'd0);
            chk("product_hold", product, last_prod);
            chk("pp_a_order", 32'(pp_a), 32'(ea));
            chk("pp_b_order", 32'(pp_b), 32'(eb));
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("product", product, exp);
        chk("pp_a_idle", 32'(pp_a), 32'd0);
        chk("pp_b_idle", 32'(pp_b), 32'd0);
        last_prod = exp;
        $display("op a=0x%04h b=0x%04h product=0x%08h expected=0x%08h", a, b, product, exp);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 32'h06260060};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h0000, 16'hBEEF, 32'h00000000};
        vecs[3] = '{16'h0001, 16'hBEEF, 32'h0000BEEF};
        vecs[4] = '{16'h00FF, 16'h0100, 32'h0000FF00};
        vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[6] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[7] = '{16'h0100, 16'h0100, 32'h00010000};

        start = 1'b0;
        a_r   = 16'h0;
        b_r   = 16'h0;
        rst_n = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_pp_a", 32'(pp_a), 32'd0);
        chk("rst_pp_b", 32'(pp_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Table-driven directed operations, issued back to back.
        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].exp);
        end

        // start held high with fresh operands every cycle: accepted only in IDLE.
        for (int c = 0; c < 15; c++) begin
            ha[c] = 16'($urandom);
            hb[c] = 16'($urandom);
        end
        for (int c = 0; c < 15; c++) begin
            a_r   = ha[c];
            b_r   = hb[c];
            start = 1'b1;
            tick();
            if (c % 5 == 4) begin
                chk("held_done", 32'(done), 32'd1);
                chk("held_product", product, 32'(ha[c-4]) * 32'(hb[c-4]));
                $display("held op a=0x%04h b=0x%04h product=0x%08h", ha[c-4], hb[c-4], product);
            end else begin
                chk("held_no_done", 32'(done), 32'd0);
                chk("held_busy", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        last_prod = 32'(ha[10]) * 32'(hb[10]);
        tick();
        chk("held_idle", 32'(busy), 32'd0);

        // Reset asserted during PP2 aborts the operation.
        a_r   = 16'h1234;
        b_r   = 16'h5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_abort_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", product, 32'd0);
        chk("abort_pp_a", 32'(pp_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_prod = 32'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end
        $display("abort during PP2 product=0x%08h", product);
        run_op(16'h0001, 16'hBEEF, 32'h0000BEEF);

        // Random operand pairs against the a*b reference.
        for (int r = 0; r < 10000; r++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, 32'(ra) * 32'(rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
